// File: rtl/rv32_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package rv32_fetch_unit_pkg;

    localparam int API_DATA_WIDTH    = 32;
    localparam int FETCH_STATE_WIDTH = 2;

    typedef logic [API_DATA_WIDTH-1:0] word_t;

    // BOOT: one idle cycle after reset; FETCH: normal; DRAIN: dropping stale responses.
    typedef enum logic [FETCH_STATE_WIDTH-1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // One buffered instruction: its PC in the upper half, the word in the lower half.
    typedef struct packed {
        word_t pc;
        word_t word;
    } fetch_entry_t;

    function automatic word_t word_align(input word_t a);
        return {a[API_DATA_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32_fetch_unit_if.sv
// Memory-side and decoder-side bus of the fetch unit, named from the fetch unit's view.
interface rv32_fetch_unit_if;
    import rv32_fetch_unit_pkg::*;

    logic  imem_req_o;
    word_t imem_addr_o;
    logic  imem_gnt_i;
    logic  imem_rvalid_i;
    word_t imem_rdata_i;
    logic  redirect_i;
    word_t redirect_pc_i;
    logic  instr_valid_o;
    logic  instr_ready_i;
    word_t instr_o;
    word_t instr_pc_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
    );

endinterface

// File: rtl/rv32_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush; flush beats push. Storage resets to RST_VAL so the
// head output has a defined value straight out of reset.
module fetch_fifo #(
    parameter int               WIDTH   = 64,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // A full FIFO may still accept a push when it is popped in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/rv32_fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// response buffering with PCs, and redirect handling with stale-response discard.
module rv32_fetch_unit
    import rv32_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC   = 32'h0000_0000,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rv32_fetch_unit_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    word_t         fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          credit_ok, req, instr_valid, gnt_fire, rsp_fire, push, pop, fifo_empty;
    word_t         redirect_pc;
    fetch_entry_t  push_entry, head;

    // Credits cover both buffered and in-flight words so a response always has a slot.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);
    assign redirect_pc = word_align(bus.redirect_pc_i);

    assign gnt_fire      = req && bus.imem_gnt_i;
    assign rsp_fire      = bus.imem_rvalid_i;
    assign outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
    // A response in a redirect cycle belongs to the old path and is always dropped.
    assign push          = rsp_fire && !bus.redirect_i && (discard_q == '0);
    assign pop           = instr_valid && bus.instr_ready_i;
    assign push_entry    = '{pc: resp_pc_q, word: bus.imem_rdata_i};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    // FSM next state; a redirect overrides every state, BOOT included.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_i) begin
            state_d = (outstanding_d != '0) ? ST_DRAIN : ST_FETCH;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_FETCH;
                ST_FETCH: state_d = ST_FETCH;
                ST_DRAIN: if (discard_d == '0) state_d = ST_FETCH;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    // FSM outputs: request only while fetching with credit; never hand out in a redirect cycle.
    always_comb begin
        req         = (state_q == ST_FETCH) && !bus.redirect_i && credit_ok;
        instr_valid = !fifo_empty && !bus.redirect_i;
    end

    // PC counters and discard count next-state.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        if (gnt_fire) fetch_pc_d = fetch_pc_q + word_t'(4);
        if (push)     resp_pc_d  = resp_pc_q + word_t'(4);
        if (rsp_fire && (discard_q != '0)) discard_d = discard_q - CW'(1);
        if (bus.redirect_i) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = outstanding_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH   (2*API_DATA_WIDTH),
        .DEPTH   (FIFO_DEPTH),
        .RST_VAL ({RESET_PC, {API_DATA_WIDTH{1'b0}}})
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (bus.redirect_i),
        .data_o  (head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = word_align(fetch_pc_q);
    assign bus.instr_valid_o = instr_valid;
    assign bus.instr_o       = head.word;
    assign bus.instr_pc_o    = head.pc;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Bench for rv32_fetch_unit: a 1-cycle memory model, directed stimulus that pushes the
// expected {pc, word} stream into a scoreboard, and a monitor that checks each transfer.
module tb_rv32_fetch_unit;
    import rv32_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv32_fetch_unit_if bus();

    rv32_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    bit          rsp_en;
    logic [63:0] exp_q [$];
    word_t       pend_q [$];

    task automatic chk(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Expected transfers: pc then pc ^ A5A5_0000 as the word the memory returns.
    task automatic push_seq(input word_t start, input int n);
        word_t pc;
        for (int k = 0; k < n; k++) begin
            pc = start + word_t'(4 * k);
            exp_q.push_back({pc, pc ^ 32'hA5A5_0000});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            #2;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: timeout with %0d transfers missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Memory: grant sampled mid-cycle, response driven in the following cycle.
    initial begin
        logic  nrv;
        word_t nrd;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        nrv = 1'b0;
        nrd = '0;
        forever begin
            @(negedge clk);
            nrv = 1'b0;
            if (!rst_n) begin
                pend_q.delete();
            end else begin
                if (bus.imem_req_o && bus.imem_gnt_i) pend_q.push_back(bus.imem_addr_o);
                if (rsp_en && pend_q.size() > 0) begin
                    nrv = 1'b1;
                    nrd = pend_q.pop_front() ^ 32'hA5A5_0000;
                end
            end
            @(posedge clk);
            #1;
            bus.imem_rvalid_i = nrv;
            bus.imem_rdata_i  = nrv ? nrd : '0;
        end
    end

    // Scoreboard monitor: every transfer must match the head of the expected queue.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.instr_valid_o && bus.instr_ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got pc %h word %h, required no transfer",
                             bus.instr_pc_o, bus.instr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.instr_pc_o !== e[63:32] || bus.instr_o !== e[31:0]) begin
                        bad++;
                        $display("FAIL sb_xfer: got pc %h word %h, required pc %h word %h",
                                 bus.instr_pc_o, bus.instr_o, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        rsp_en            = 1'b1;
        bus.imem_gnt_i    = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b0;
        #3;
        chk("rst_req",   word_t'(bus.imem_req_o),    32'h0);
        chk("rst_addr",  bus.imem_addr_o,            32'h0);
        chk("rst_valid", word_t'(bus.instr_valid_o), 32'h0);
        chk("rst_instr", bus.instr_o,                32'h0);
        chk("rst_pc",    bus.instr_pc_o,             32'h0);

        // Streaming from reset: request in cycle 1, first instruction in cycle 3, then 1/cycle.
        @(negedge clk);
        rst_n = 1'b1;
        push_seq(32'h0, 16);
        #2 chk("boot_no_req", word_t'(bus.imem_req_o), 32'h0);
        step(); bus.instr_ready_i = 1'b1;
        #1 chk("c1_req",  word_t'(bus.imem_req_o), 32'h1);
        chk("c1_addr", bus.imem_addr_o, 32'h0);
        step(); #1 chk("c2_valid", word_t'(bus.instr_valid_o), 32'h0);
        step(); #1 chk("c3_valid", word_t'(bus.instr_valid_o), 32'h1);
        chk("c3_pc", bus.instr_pc_o, 32'h0);
        repeat (16) begin @(negedge clk); #2; end
        chk("throughput_left", word_t'(exp_q.size()), 32'h0);

        // Decoder stalled 10 cycles: fetch stops on credit, head holds pc 0x40.
        step(); bus.instr_ready_i = 1'b0;
        #1 chk("stall_pc_early", bus.instr_pc_o, 32'h40);
        repeat (9) step();
        #1 chk("stall_req",   word_t'(bus.imem_req_o),    32'h0);
        chk("stall_valid", word_t'(bus.instr_valid_o), 32'h1);
        chk("stall_pc",    bus.instr_pc_o,             32'h40);
        chk("stall_instr", bus.instr_o,                32'h40 ^ 32'hA5A5_0000);
        push_seq(32'h40, 16);
        bus.instr_ready_i = 1'b1;
        wait_empty("stall_resume", 60);
        step(); bus.instr_ready_i = 1'b0;

        // Redirect with full FIFO, then build 2 outstanding with responses held, grant withheld.
        repeat (6) step();
        rsp_en = 1'b0;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h80;
        #1 chk("r80_valid", word_t'(bus.instr_valid_o), 32'h0);
        chk("r80_req", word_t'(bus.imem_req_o), 32'h0);
        step(); bus.redirect_i = 1'b0;
        #1 chk("r80_req1", word_t'(bus.imem_req_o), 32'h1);
        chk("r80_addr1", bus.imem_addr_o, 32'h80);
        step(); #1 chk("r80_addr2", bus.imem_addr_o, 32'h84);
        step(); bus.imem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            #1 chk("nognt_req", word_t'(bus.imem_req_o), 32'h1);
            chk("nognt_addr", bus.imem_addr_o, 32'h88);
        end
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100; rsp_en = 1'b1;
        #1 chk("r100_req", word_t'(bus.imem_req_o), 32'h0);
        chk("r100_valid", word_t'(bus.instr_valid_o), 32'h0);
        step(); bus.redirect_i = 1'b0; bus.imem_gnt_i = 1'b1;
        #1 chk("drain_drop1_req", word_t'(bus.imem_req_o), 32'h0);
        step(); #1 chk("drain_drop2_req", word_t'(bus.imem_req_o), 32'h0);
        step(); push_seq(32'h100, 8); bus.instr_ready_i = 1'b1;
        #1 chk("after_drain_req", word_t'(bus.imem_req_o), 32'h1);
        chk("after_drain_addr", bus.imem_addr_o, 32'h100);
        wait_empty("r100_stream", 40);

        // Redirect to an unaligned target while a response is arriving.
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h203;
        push_seq(32'h200, 8);
        #1 chk("r203_valid", word_t'(bus.instr_valid_o), 32'h0);
        chk("r203_req", word_t'(bus.imem_req_o), 32'h0);
        step(); bus.redirect_i = 1'b0;
        #1 chk("r203_addr", bus.imem_addr_o, 32'h200);
        chk("r203_req1", word_t'(bus.imem_req_o), 32'h1);
        wait_empty("r203_stream", 40);

        // Fetch address wraps past the top of the address space.
        step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFF8;
        push_seq(32'hFFFF_FFF8, 5);
        step(); bus.redirect_i = 1'b0;
        #1 chk("wrap_a0", bus.imem_addr_o, 32'hFFFF_FFF8);
        step(); #1 chk("wrap_a1", bus.imem_addr_o, 32'hFFFF_FFFC);
        step(); #1 chk("wrap_a2", bus.imem_addr_o, 32'h0000_0000);
        wait_empty("wrap_stream", 40);

        // Asynchronous reset mid-stream, then restart from RESET_PC.
        step(); #2 rst_n = 1'b0;
        #1 chk("mrst_req",   word_t'(bus.imem_req_o),    32'h0);
        chk("mrst_addr",  bus.imem_addr_o,            32'h0);
        chk("mrst_valid", word_t'(bus.instr_valid_o), 32'h0);
        chk("mrst_instr", bus.instr_o,                32'h0);
        chk("mrst_pc",    bus.instr_pc_o,             32'h0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_seq(32'h0, 8);
        #2 chk("mrst_boot_req", word_t'(bus.imem_req_o), 32'h0);
        step(); #1 chk("mrst_c1_req", word_t'(bus.imem_req_o), 32'h1);
        chk("mrst_c1_addr", bus.imem_addr_o, 32'h0);
        wait_empty("mrst_stream", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
